// File: rtl/ov7670_axil_regbank.sv
// AXI4-Lite slave register bank for the OV7670 stream IP.
// Parametrised register count, per-byte write strobes, read-only status
// registers sourced from reg_in, and SLVERR for out-of-range or RO writes.
// AW and W are latched independently so they may arrive in any order.
module ov7670_axil_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_NUM_REGS = 8,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK = '0
) (
  input  logic                                     ACLK,
  input  logic                                     ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                               S_AXI_AWPROT,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                               S_AXI_ARPROT,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [C_NUM_REGS-1:0]                    reg_wr
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W   = DW / 8;
  localparam int ADDR_LSB = (DW == 64) ? 3 : 2;
  localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write-path state
  logic                  aw_held_reg;
  logic                  w_held_reg;
  logic [IDX_W-1:0]      aw_idx_reg;
  logic [DW-1:0]         w_data_reg;
  logic [STRB_W-1:0]     w_strb_reg;
  logic                  bvalid_reg;
  logic [1:0]            bresp_reg;
  logic [C_NUM_REGS-1:0] reg_wr_reg;

  // Read-path state
  logic                  rvalid_reg;
  logic [1:0]            rresp_reg;
  logic [DW-1:0]         rdata_reg;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      ar_idx;
  logic [DW-1:0]         wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [C_NUM_REGS-1:0] wr_hit;
  logic [DW-1:0]         reg_q    [C_NUM_REGS];
  logic [DW-1:0]         reg_in_a [C_NUM_REGS];
  logic [DW-1:0]         rd_data_next;
  logic [1:0]            rd_resp_next;

  // Protection bits and sub-word address bits carry no meaning here
  logic unused_ok;
  assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  assign S_AXI_AWREADY = !aw_held_reg && !bvalid_reg;
  assign S_AXI_WREADY  = !w_held_reg && !bvalid_reg;
  assign S_AXI_ARREADY = !rvalid_reg;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_BRESP   = bresp_reg;
  assign S_AXI_RVALID  = rvalid_reg;
  assign S_AXI_RRESP   = rresp_reg;
  assign S_AXI_RDATA   = rdata_reg;
  assign reg_wr        = reg_wr_reg;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // A commit needs both halves, each either latched earlier or arriving now
  assign commit  = (aw_held_reg || aw_hs) && (w_held_reg || w_hs);
  assign wr_idx  = aw_held_reg ? aw_idx_reg : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign wr_data = w_held_reg ? w_data_reg : S_AXI_WDATA;
  assign wr_strb = w_held_reg ? w_strb_reg : S_AXI_WSTRB;
  assign ar_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];

  // Per-register storage; RO slots hold nothing and read as zero on reg_out
  genvar gi;
  generate
    for (gi = 0; gi < C_NUM_REGS; gi++) begin : g_reg
      assign reg_in_a[gi] = reg_in[gi*DW +: DW];
      assign reg_out[gi*DW +: DW] = reg_q[gi];
      if (C_RO_MASK[gi]) begin : g_ro
        assign wr_hit[gi] = 1'b0;
        assign reg_q[gi]  = '0;
      end else begin : g_rw
        logic [DW-1:0] data_reg;
        assign wr_hit[gi] = commit && (wr_idx == IDX_W'(gi));
        assign reg_q[gi]  = data_reg;
        // Byte-masked update on a committed write to this register
        always_ff @(posedge ACLK or negedge ARESETN) begin
          if (!ARESETN) begin
            data_reg <= '0;
          end else if (wr_hit[gi]) begin
            for (int b = 0; b < STRB_W; b++) begin
              if (wr_strb[b]) data_reg[b*8 +: 8] <= wr_data[b*8 +: 8];
            end
          end
        end
      end
    end
  endgenerate

  // Write channel: latch AW/W independently, commit when both present, hold B
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      aw_idx_reg  <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
      reg_wr_reg  <= '0;
    end else begin
      reg_wr_reg <= wr_hit;
      if (commit) begin
        aw_held_reg <= 1'b0;
        w_held_reg  <= 1'b0;
        bvalid_reg  <= 1'b1;
        bresp_reg   <= (|wr_hit) ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_held_reg <= 1'b1;
          aw_idx_reg  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
        end
        if (w_hs) begin
          w_held_reg <= 1'b1;
          w_data_reg <= S_AXI_WDATA;
          w_strb_reg <= S_AXI_WSTRB;
        end
        if (bvalid_reg && S_AXI_BREADY) bvalid_reg <= 1'b0;
      end
    end
  end

  // Read mux: RW storage, live status input for RO slots, SLVERR when unmapped
  always_comb begin
    rd_data_next = '0;
    rd_resp_next = RESP_SLVERR;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_resp_next = RESP_OKAY;
        rd_data_next = C_RO_MASK[i] ? reg_in_a[i] : reg_q[i];
      end
    end
  end

  // Read channel: register the response on AR handshake, hold until RREADY
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_reg <= 1'b0;
      rresp_reg  <= RESP_OKAY;
      rdata_reg  <= '0;
    end else if (ar_hs) begin
      rvalid_reg <= 1'b1;
      rresp_reg  <= rd_resp_next;
      rdata_reg  <= rd_data_next;
    end else if (rvalid_reg && S_AXI_RREADY) begin
      rvalid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ov7670_axil_regbank.sv
// Testbench for ov7670_axil_regbank: directed AXI-Lite transactions with
// literal expectations, then randomized traffic, all tracked by a queue-based
// transaction model that is compared against the DUT every clock.
module tb_ov7670_axil_regbank;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam logic [N-1:0] RO_MASK = 8'h80;

  logic            ACLK;
  logic            ARESETN;
  logic [AW-1:0]   S_AXI_AWADDR;
  logic [2:0]      S_AXI_AWPROT;
  logic            S_AXI_AWVALID;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WVALID;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic [2:0]      S_AXI_ARPROT;
  logic            S_AXI_ARVALID;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY;
  logic [N*DW-1:0] reg_out;
  logic [N*DW-1:0] reg_in;
  logic [N-1:0]    reg_wr;

  ov7670_axil_regbank #(
    .C_S_AXI_DATA_WIDTH(DW),
    .C_S_AXI_ADDR_WIDTH(AW),
    .C_NUM_REGS(N),
    .C_RO_MASK(RO_MASK)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .reg_in(reg_in), .reg_wr(reg_wr)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ---------------- transaction-level model ----------------
  logic [DW-1:0] mregs [N];
  int            aw_q [$];
  logic [35:0]   w_q  [$];
  bit            m_b = 0, m_r = 0;
  logic [1:0]    m_bresp = 0, m_rresp = 0;
  logic [DW-1:0] m_rdata = 0;
  logic [N-1:0]  m_wr = 0;

  initial begin : model
    bit awr, wrd, arr;
    int ridx, widx;
    logic [35:0] wb;
    for (int i = 0; i < N; i++) mregs[i] = '0;
    forever begin
      @(posedge ACLK or negedge ARESETN);
      if (!ARESETN) begin
        aw_q.delete(); w_q.delete();
        m_b = 0; m_r = 0; m_bresp = 0; m_rresp = 0; m_rdata = 0; m_wr = 0;
        for (int i = 0; i < N; i++) mregs[i] = '0;
      end else begin
        // acceptance is decided by the state before this edge
        awr = (aw_q.size() == 0) && !m_b;
        wrd = (w_q.size() == 0) && !m_b;
        arr = !m_r;
        m_wr = '0;
        if (m_b && S_AXI_BREADY) m_b = 0;
        if (m_r && S_AXI_RREADY) m_r = 0;
        // read sees register contents before any write committing this edge
        if (S_AXI_ARVALID && arr) begin
          ridx = int'(S_AXI_ARADDR) / 4;
          m_r = 1;
          if (ridx >= N) begin
            m_rdata = '0; m_rresp = 2'b10;
          end else if (RO_MASK[ridx[2:0]]) begin
            m_rdata = reg_in[ridx*DW +: DW]; m_rresp = 2'b00;
          end else begin
            m_rdata = mregs[ridx]; m_rresp = 2'b00;
          end
        end
        if (S_AXI_AWVALID && awr) aw_q.push_back(int'(S_AXI_AWADDR) / 4);
        if (S_AXI_WVALID && wrd) w_q.push_back({S_AXI_WSTRB, S_AXI_WDATA});
        if (aw_q.size() > 0 && w_q.size() > 0) begin
          widx = aw_q.pop_front();
          wb   = w_q.pop_front();
          m_b  = 1;
          if (widx < N && !RO_MASK[widx[2:0]]) begin
            for (int b = 0; b < 4; b++)
              if (wb[32+b]) mregs[widx][8*b +: 8] = wb[8*b +: 8];
            m_wr[widx[2:0]] = 1'b1;
            m_bresp = 2'b00;
          end else begin
            m_bresp = 2'b10;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin : compare
    forever begin
      @(negedge ACLK);
      chk("awready", S_AXI_AWREADY, (aw_q.size() == 0) && !m_b);
      chk("wready", S_AXI_WREADY, (w_q.size() == 0) && !m_b);
      chk("arready", S_AXI_ARREADY, !m_r);
      chk("bvalid", S_AXI_BVALID, m_b);
      if (m_b) chk("bresp", S_AXI_BRESP, m_bresp);
      chk("rvalid", S_AXI_RVALID, m_r);
      if (m_r) begin
        chk("rdata", S_AXI_RDATA, m_rdata);
        chk("rresp", S_AXI_RRESP, m_rresp);
      end
      chk("reg_wr", reg_wr, m_wr);
      for (int i = 0; i < N; i++)
        chk($sformatf("reg_out[%0d]", i), reg_out[i*DW +: DW], RO_MASK[i] ? '0 : mregs[i]);
    end
  end

  // ---------------- directed transaction tasks ----------------
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input bit wait_b, input logic [N-1:0] exp_wr,
                           output logic [1:0] resp);
    int c;
    bit aw_done, w_done, awf, wf;
    c = 0; aw_done = 0; w_done = 0; resp = 2'b11;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    while (!(aw_done && w_done) && c < 40) begin
      S_AXI_AWVALID = !aw_done && (c >= aw_dly);
      S_AXI_WVALID  = !w_done && (c >= w_dly);
      @(negedge ACLK);
      if (w_done && !aw_done) chk("wready_low_after_w", S_AXI_WREADY, 0);
      if (aw_done && !w_done) chk("awready_low_after_aw", S_AXI_AWREADY, 0);
      awf = S_AXI_AWVALID && S_AXI_AWREADY;
      wf  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      aw_done = aw_done || awf;
      w_done  = w_done || wf;
      c++;
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    if (!(aw_done && w_done)) begin
      bound_expired("write_handshake");
      return;
    end
    chk("bvalid_one_cycle_after_hs", S_AXI_BVALID, 1);
    chk("reg_wr_pulse", reg_wr, exp_wr);
    resp = S_AXI_BRESP;
    $display("write addr=0x%02h data=0x%08h strb=%b resp=%0d", addr, data, strb, resp);
    if (wait_b) begin
      S_AXI_BREADY = 1;
      @(posedge ACLK); #1;
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                          output logic [1:0] resp);
    int c;
    bit arf;
    c = 0; arf = 0; data = '0; resp = 2'b11;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1; S_AXI_RREADY = 1;
    while (!arf && c < 40) begin
      @(negedge ACLK);
      arf = S_AXI_ARVALID && S_AXI_ARREADY;
      @(posedge ACLK); #1;
      c++;
    end
    S_AXI_ARVALID = 0;
    if (!arf) begin
      bound_expired("read_handshake");
      return;
    end
    chk("rvalid_one_cycle_after_hs", S_AXI_RVALID, 1);
    data = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    $display("read  addr=0x%02h data=0x%08h resp=%0d", addr, data, resp);
    @(posedge ACLK); #1;
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] wr_vals [4];
  logic [DW-1:0] rd;
  logic [1:0]    rs;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit awf, wf, arf;
    ARESETN = 0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 0; S_AXI_BREADY = 1;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 0; S_AXI_RREADY = 1;
    reg_in = '0;
    reg_in[7*DW +: DW] = 32'hCAFE0007;
    wr_vals[0] = 32'h0101FFFF; wr_vals[1] = 32'habcd0001;
    wr_vals[2] = 32'hdead0011; wr_vals[3] = 32'hbeef0011;

    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_awready", S_AXI_AWREADY, 1);
    chk("rst_wready", S_AXI_WREADY, 1);
    chk("rst_arready", S_AXI_ARREADY, 1);
    chk("rst_bvalid", S_AXI_BVALID, 0);
    chk("rst_rvalid", S_AXI_RVALID, 0);
    chk("rst_rdata", S_AXI_RDATA, 0);
    chk("rst_bresp", S_AXI_BRESP, 0);
    chk("rst_rresp", S_AXI_RRESP, 0);
    chk("rst_reg_out", reg_out[63:0], 0);
    ARESETN = 1;

    // Both channels in the same cycle, then read each back
    for (int i = 0; i < 4; i++) begin
      axi_write(AW'(i*4), wr_vals[i], 4'hF, 0, 0, 1, N'(1 << i), rs);
      chk("bresp_okay", rs, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(AW'(i*4), rd, rs);
      chk("readback", rd, wr_vals[i]);
      chk("rresp_okay", rs, 2'b00);
    end

    // W three cycles ahead of AW
    axi_write(6'h10, 32'h12345678, 4'hF, 3, 0, 1, 8'h10, rs);
    chk("w_first_bresp", rs, 2'b00);
    chk("w_first_reg_out4", reg_out[4*DW +: DW], 32'h12345678);

    // AW two cycles ahead of W
    axi_write(6'h08, 32'h0badf00d, 4'hF, 0, 2, 1, 8'h04, rs);
    chk("aw_first_reg_out2", reg_out[2*DW +: DW], 32'h0badf00d);

    // Byte strobes on register 1
    axi_write(6'h04, 32'hFFFFFFFF, 4'b0101, 0, 0, 1, 8'h02, rs);
    axi_read(6'h04, rd, rs);
    chk("strobe_readback", rd, 32'habFF00FF);
    chk("model_strobe_reg1", mregs[1], 32'habFF00FF);

    // Read-only register 7
    axi_write(6'h1C, 32'h00000001, 4'hF, 0, 0, 1, 8'h00, rs);
    chk("ro_write_slverr", rs, 2'b10);
    axi_read(6'h1C, rd, rs);
    chk("ro_read_data", rd, 32'hCAFE0007);
    chk("ro_read_okay", rs, 2'b00);

    // Out of range
    axi_write(6'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 1, 8'h00, rs);
    chk("oor_write_slverr", rs, 2'b10);
    axi_read(6'h20, rd, rs);
    chk("oor_read_data", rd, 0);
    chk("oor_read_slverr", rs, 2'b10);
    chk("oor_no_change_reg0", reg_out[0 +: DW], 32'h0101FFFF);

    // Backpressure on B, then asynchronous reset in the middle of the hold
    S_AXI_BREADY = 0;
    axi_write(6'h18, 32'h00000055, 4'hF, 0, 0, 0, 8'h40, rs);
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      chk("bp_bvalid_held", S_AXI_BVALID, 1);
      chk("bp_awready_low", S_AXI_AWREADY, 0);
      chk("bp_wready_low", S_AXI_WREADY, 0);
      @(posedge ACLK); #1;
    end
    #1;
    ARESETN = 0;
    #1;
    chk("async_rst_bvalid", S_AXI_BVALID, 0);
    for (int i = 0; i < N; i++)
      chk($sformatf("async_rst_reg%0d", i), reg_out[i*DW +: DW], 0);
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1;
    S_AXI_BREADY = 1;

    // Randomized traffic; valids are held until accepted
    for (int c = 0; c < 3000; c++) begin
      @(negedge ACLK);
      awf = S_AXI_AWVALID && S_AXI_AWREADY;
      wf  = S_AXI_WVALID && S_AXI_WREADY;
      arf = S_AXI_ARVALID && S_AXI_ARREADY;
      @(posedge ACLK); #1;
      if (!S_AXI_AWVALID || awf) begin
        S_AXI_AWVALID = ($urandom_range(0, 2) != 0);
        S_AXI_AWADDR  = AW'($urandom_range(0, 39));
      end
      if (!S_AXI_WVALID || wf) begin
        S_AXI_WVALID = ($urandom_range(0, 2) != 0);
        S_AXI_WDATA  = $urandom;
        S_AXI_WSTRB  = 4'($urandom);
      end
      if (!S_AXI_ARVALID || arf) begin
        S_AXI_ARVALID = ($urandom_range(0, 1) != 0);
        S_AXI_ARADDR  = AW'($urandom_range(0, 39));
      end
      S_AXI_BREADY = ($urandom_range(0, 3) != 0);
      S_AXI_RREADY = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) reg_in[i*DW +: DW] = $urandom;
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    repeat (4) @(posedge ACLK);
    #1;

    // Read everything back against the model's view of the bank
    for (int i = 0; i < N; i++) begin
      axi_read(AW'(i*4), rd, rs);
      chk($sformatf("final_read%0d", i), rd, RO_MASK[i] ? reg_in[i*DW +: DW] : mregs[i]);
      chk("final_rresp", rs, 2'b00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ov7670_axil_regbank.md
# ov7670_axil_regbank

Parametrised AXI4-Lite slave register bank for the OV7670 stream IP. It replaces the fixed four-register slave with a configurable number of registers, per-byte write strobes, read-only status registers fed from the datapath, and SLVERR for illegal accesses. AW and W may arrive in any order or in the same cycle. It sits between the AXI4-Lite interconnect and the capture/decode control logic.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32: data width; 32 or 64 only.
- C_S_AXI_ADDR_WIDTH, 6: byte address width; must satisfy 2^C_S_AXI_ADDR_WIDTH ≥ C_NUM_REGS·(C_S_AXI_DATA_WIDTH/8).
- C_NUM_REGS, 8: register count, 1..64.
- C_RO_MASK, 0: C_NUM_REGS-bit mask; bit i=1 makes register i read-only, returning reg_in slice i.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data.
- S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte strobes.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response: 00 OKAY, 10 SLVERR.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- reg_out  out  C_NUM_REGS·C_S_AXI_DATA_WIDTH  flattened register contents; register i occupies slice i. RO slices are driven 0.
- reg_in  in  C_NUM_REGS·C_S_AXI_DATA_WIDTH  status inputs; only RO slices are used.
- reg_wr  out  C_NUM_REGS  one-cycle pulse on bit i when register i is written.

## Operation
- Word index = AWADDR/ARADDR >> log2(C_S_AXI_DATA_WIDTH/8). Low address bits are ignored.
- Write path holds two latches, aw_held and w_held.
  - AWREADY = !aw_held && !BVALID.
  - WREADY = !w_held && !BVALID.
  - A handshake on either channel sets its latch and captures the address or data+strobe.
- Commit occurs in the cycle where both (latched or current-cycle handshake) are present. At that edge:
  - If index < C_NUM_REGS and C_RO_MASK[index]=0: update each byte b where WSTRB[b]=1, pulse reg_wr[index], set BRESP=OKAY.
  - Otherwise: no register change, no pulse, set BRESP=SLVERR.
  - Set BVALID and clear both latches.
- BVALID holds until BREADY is sampled high. It clears on that edge. New AW/W is accepted from the following cycle.
- Read path: ARREADY = !RVALID. On an AR handshake, RDATA/RRESP are registered and RVALID is set.
  - RW register: RDATA = register, RRESP = OKAY.
  - RO register: RDATA = reg_in slice sampled at the handshake edge, RRESP = OKAY.
  - Out-of-range index: RDATA = 0, RRESP = SLVERR.
- RVALID, RDATA and RRESP are held stable until RREADY is sampled high.
- Read and write paths are independent and may complete in the same cycle.

## Timing
- Reset (ARESETN low, asynchronous) clears:
  - all registers to 0;
  - BVALID, RVALID, reg_wr, aw_held and w_held to 0;
  - BRESP, RRESP and RDATA to 0.
- AWREADY, WREADY and ARREADY are therefore 1 during and after reset.
- Write latency:
  - AW and W in the same cycle: BVALID one cycle later; reg_out updated in the same cycle as BVALID rises.
  - AW and W separated by N cycles: BVALID one cycle after the later handshake.
- Read latency: RVALID one cycle after the AR handshake.
- Back-to-back throughput:
  - With BREADY held high, one write every 2 cycles.
  - With RREADY held high, one read every 2 cycles.
- A read and a write to the same register with the AR handshake on the commit edge return the pre-write value.
- Reset asserted mid-transaction:
  - Any pending latch or response is discarded immediately.
  - No commit occurs.
  - The master must reissue the transaction.

## Test plan
- Defaults, both channels in the same cycle: write 0x0101FFFF, 0xabcd0001, 0xdead0011 and 0xbeef0011 to addresses 0x00, 0x04, 0x08 and 0x0C, then read each back.
  - Expect BRESP=OKAY and RRESP=OKAY.
  - Expect matching RDATA.
  - Expect BVALID and RVALID each one cycle after the handshake.
  - Expect reg_wr pulses on bits 0..3.
- W three cycles before AW, addr 0x10, data 0x12345678:
  - Expect WREADY low after the W handshake.
  - Expect BVALID one cycle after AW.
  - Expect reg_out slice 4 = 0x12345678.
- Strobes: register 1 holds 0xabcd0001; write 0xFFFFFFFF with WSTRB=4'b0101.
  - Expect a readback of 0xabFF00FF.
- C_RO_MASK=8'h80, reg_in slice 7 = 0xCAFE0007:
  - Write 0x1 to 0x1C: expect SLVERR, no reg_wr[7] pulse.
  - Read 0x1C: expect 0xCAFE0007 with OKAY.
- Out-of-range access: write and read 0x20 (C_NUM_REGS=8, ADDR_WIDTH=6).
  - Expect SLVERR on both, RDATA=0, no register change.
- Backpressure and reset:
  - Hold BREADY low for 5 cycles: expect BVALID stable, AWREADY=WREADY=0.
  - Assert ARESETN low mid-hold: expect BVALID=0 asynchronously and all registers=0.
